fixed_point_division: RTL and testbench

//   Sequential unsigned fixed-point divider: q = A / B, with A, B and q all in Q5.5 format.

---
 rtl/fixed_point_division_if.sv | 23 ++
 rtl/fixed_point_division.sv | 123 ++++++++++++
 tb/tb_fixed_point_division.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_division_if.sv
// Operand/result bundle for the Q5.5 sequential divider.
// The master drives operands, loads and start; the slave returns the quotient and flag.
interface fixed_point_division_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             ld_a;
    logic             ld_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic             ov;

    modport master (
        output start, ld_a, ld_b, a, b,
        input  q, ov
    );

    modport slave (
        input  start, ld_a, ld_b, a, b,
        output q, ov
    );
endinterface

// File: rtl/fixed_point_division.sv
// Unsigned Q5.5 restoring divider, one quotient bit per clock.
// Saturates to all ones with ov set on divide-by-zero or quotient overflow.
module fixed_point_division #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fixed_point_division_if.slave   bus
);
    localparam int DW = WIDTH + FRAC;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [DW-1:0]    d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ov_q, ov_d;
    logic [WIDTH+1:0] rShift;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        zdiv_d  = zdiv_q;
        q_d     = q_q;
        ov_d    = ov_q;
        // The extra top bit keeps the compare exact even when the shifted remainder exceeds WIDTH bits.
        rShift  = {r_q, d_q[DW-1]};

        case (state_q)
            IDLE: begin
                if (bus.ld_a) ra_d = bus.a;
                if (bus.ld_b) rb_d = bus.b;
                if (bus.start) begin
                    ov_d    = 1'b0;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (rb_q == '0) begin
                    zdiv_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    zdiv_d  = 1'b0;
                    d_d     = {ra_q, {FRAC{1'b0}}};
                    r_d     = '0;
                    quot_d  = '0;
                    cnt_d   = CNT_INIT;
                    state_d = DIV;
                end
            end
            DIV: begin
                d_d = {d_q[DW-2:0], 1'b0};
                if (rShift >= {2'b00, rb_q}) begin
                    r_d    = rShift[WIDTH:0] - {1'b0, rb_q};
                    quot_d = {quot_q[DW-2:0], 1'b1};
                end else begin
                    r_d    = rShift[WIDTH:0];
                    quot_d = {quot_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                if (zdiv_q || (|quot_q[DW-1:WIDTH])) begin
                    q_d  = '1;
                    ov_d = 1'b1;
                end else begin
                    q_d  = quot_q[WIDTH-1:0];
                    ov_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            zdiv_q  <= 1'b0;
            q_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            zdiv_q  <= zdiv_d;
            q_q     <= q_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.q  = q_q;
    assign bus.ov = ov_q;
endmodule

// File: tb/tb_fixed_point_division.sv
// Self-checking bench for the Q5.5 divider: directed vectors, random operands against
// an arithmetic reference, zero-divide, mid-division reset, busy loads and held start.
module tb_fixed_point_division;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fixed_point_division_if #(.WIDTH(10)) bus();

    fixed_point_division #(.WIDTH(10), .FRAC(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [9:0] lastQ  = 10'd0;
    logic       lastOv = 1'b0;

    // Reference: exact integer quotient of (A * 2^FRAC) / B, saturated to 10 bits.
    function automatic void model(input logic [9:0] a, input logic [9:0] b,
                                  output logic [9:0] q, output logic ov);
        int quot;
        if (b == 10'd0) begin
            q  = 10'h3FF;
            ov = 1'b1;
        end else begin
            quot = (int'(a) * 32) / int'(b);
            if (quot > 1023) begin
                q  = 10'h3FF;
                ov = 1'b1;
            end else begin
                q  = quot[9:0];
                ov = 1'b0;
            end
        end
    endfunction

    task automatic launch(input logic [9:0] a, input logic [9:0] b, input logic doA, input logic doB);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.ld_a  = doA;
        bus.ld_b  = doB;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ld_a  = 1'b0;
        bus.ld_b  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.q !== 10'd0 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: q=%h ov=%b, expected q=000 ov=0", bus.q, bus.ov);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [9:0] va [4] = '{10'h020, 10'h0F0, 10'h3E0, 10'h020};
        logic [9:0] vb [4] = '{10'h010, 10'h030, 10'h001, 10'h060};
        logic [9:0] eq [4] = '{10'h040, 10'h0A0, 10'h3FF, 10'h00A};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], 1'b1, 1'b1);
            repeat (16) @(posedge clk);
            #1;
            checks++;
            if (bus.q !== lastQ || bus.ov !== 1'b0) begin
                fails++;
                $display("[TB] FAIL directed_hold[%0d]: q=%h ov=%b, expected q=%h ov=0", i, bus.q, bus.ov, lastQ);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.q !== eq[i] || bus.ov !== eo[i]) begin
                fails++;
                $display("[TB] FAIL directed[%0d]: q=%h ov=%b, expected q=%h ov=%b", i, bus.q, bus.ov, eq[i], eo[i]);
            end
            lastQ  = eq[i];
            lastOv = eo[i];
        end
    endtask

    task automatic test_zero_div();
        logic [9:0] expQ;
        logic       expOv;
        launch(10'h0F0, 10'h000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.q !== lastQ || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zdiv_hold: q=%h ov=%b, expected q=%h ov=0", bus.q, bus.ov, lastQ);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'h3FF || bus.ov !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zdiv: q=%h ov=%b, expected q=3ff ov=1", bus.q, bus.ov);
        end
        // A following normal division proves the unit went back to idle.
        launch(10'h0F0, 10'h030, 1'b1, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        model(10'h0F0, 10'h030, expQ, expOv);
        checks++;
        if (bus.q !== expQ || bus.ov !== expOv) begin
            fails++;
            $display("[TB] FAIL zdiv_recover: q=%h ov=%b, expected q=%h ov=%b", bus.q, bus.ov, expQ, expOv);
        end
        lastQ  = expQ;
        lastOv = expOv;
    endtask

    task automatic test_random();
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] expQ;
        logic       expOv;
        int         lat;
        for (int i = 0; i < 24; i++) begin
            a = 10'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0:       b = 10'($urandom_range(1, 31));
                1:       b = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(32, 1023));
                default: b = 10'($urandom_range(0, 1023));
            endcase
            model(a, b, expQ, expOv);
            lat = (b == 10'd0) ? 2 : 17;
            launch(a, b, 1'b1, 1'b1);
            repeat (lat - 1) @(posedge clk);
            #1;
            checks++;
            if (bus.q !== lastQ || bus.ov !== 1'b0) begin
                fails++;
                $display("[TB] FAIL random_hold[%0d]: q=%h ov=%b, expected q=%h ov=0", i, bus.q, bus.ov, lastQ);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.q !== expQ || bus.ov !== expOv) begin
                fails++;
                $display("[TB] FAIL random[%0d] a=%h b=%h: q=%h ov=%b, expected q=%h ov=%b",
                         i, a, b, bus.q, bus.ov, expQ, expOv);
            end
            lastQ  = expQ;
            lastOv = expOv;
        end
    endtask

    task automatic test_reset_mid();
        launch(10'h0F0, 10'h030, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.q !== 10'd0 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_async: q=%h ov=%b, expected q=000 ov=0", bus.q, bus.ov);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'd0 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_abort: q=%h ov=%b, expected q=000 ov=0", bus.q, bus.ov);
        end
        // RB was cleared by reset, so a start loading only A must divide by zero.
        launch(10'h020, 10'h010, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'h3FF || bus.ov !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_rb_clear: q=%h ov=%b, expected q=3ff ov=1", bus.q, bus.ov);
        end
        launch(10'h020, 10'h010, 1'b1, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'h040 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_recover: q=%h ov=%b, expected q=040 ov=0", bus.q, bus.ov);
        end
        lastQ  = 10'h040;
        lastOv = 1'b0;
    endtask

    task automatic test_busy_load();
        logic [9:0] expQ;
        logic       expOv;
        launch(10'h0F0, 10'h030, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #4;
        bus.a     = 10'h3E0;
        bus.b     = 10'h001;
        bus.ld_a  = 1'b1;
        bus.ld_b  = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.ld_a  = 1'b0;
        bus.ld_b  = 1'b0;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== lastQ || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_hold: q=%h ov=%b, expected q=%h ov=0", bus.q, bus.ov, lastQ);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'h0A0 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_load: q=%h ov=%b, expected q=0a0 ov=0", bus.q, bus.ov);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 10'h0A0 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL busy_start_ignored: q=%h ov=%b, expected q=0a0 ov=0", bus.q, bus.ov);
        end
        // Divisor register must still hold 0x030 from before the busy load.
        launch(10'h020, 10'h3FF, 1'b1, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        model(10'h020, 10'h030, expQ, expOv);
        checks++;
        if (bus.q !== expQ || bus.ov !== expOv) begin
            fails++;
            $display("[TB] FAIL busy_rb_kept: q=%h ov=%b, expected q=%h ov=%b", bus.q, bus.ov, expQ, expOv);
        end
        lastQ  = expQ;
        lastOv = expOv;
    endtask

    task automatic test_back_to_back();
        logic [9:0] q1, q2;
        logic       o1, o2;
        model(10'h1A5, 10'h047, q1, o1);
        model(10'h0C3, 10'h011, q2, o2);
        @(negedge clk);
        bus.a     = 10'h1A5;
        bus.b     = 10'h047;
        bus.ld_a  = 1'b1;
        bus.ld_b  = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 10'h0C3;
        bus.b = 10'h011;
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== q1 || bus.ov !== o1) begin
            fails++;
            $display("[TB] FAIL b2b_first: q=%h ov=%b, expected q=%h ov=%b", bus.q, bus.ov, q1, o1);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ld_a  = 1'b0;
        bus.ld_b  = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== q1 || bus.ov !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_hold: q=%h ov=%b, expected q=%h ov=0", bus.q, bus.ov, q1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.q !== q2 || bus.ov !== o2) begin
            fails++;
            $display("[TB] FAIL b2b_second: q=%h ov=%b, expected q=%h ov=%b", bus.q, bus.ov, q2, o2);
        end
        lastQ  = q2;
        lastOv = o2;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.ld_a  = 1'b0;
        bus.ld_b  = 1'b0;
        bus.a     = 10'd0;
        bus.b     = 10'd0;
        test_reset();
        test_directed();
        test_zero_div();
        test_random();
        test_reset_mid();
        test_busy_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
